melody_recorder: RTL
====================

Name: melody_recorder

Overview:
- Writer counterpart to the ROM-driven tone player.
- Captures a live 7-bit key stream, for example from the on-screen keyboard or mouse, and records it as (key, duration-ms) pairs. The pairs go into a dual-port melody RAM in the same layout the player reads.
- Layout: address 0 holds the note count; address 1 is 0; pair n sits at addresses 2n+2 (key) and 2n+3 (time).
- Once recording finishes, the player can replay the RAM unchanged.

Parameters:
- CLOCK_FREQUENCY, 50000000: clock rate in Hz; one ms tick every CLOCK_FREQUENCY/1000 cycles.
- ADDRESS_BITS, 7: RAM address width; legal range 3..8.
- MAX_MS, 65535: segment duration limit in ms; must be ≤ 65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- enable  in  1  when high the block advances; when low all counters and state freeze and wrEnable is 0.
- record  in  1  active-low start request, level-sampled.
- stop  in  1  active-high, one-cycle stop request.
- key  in  7  current key, synchronous to clock; 0 means rest.
- wrAddress  out  ADDRESS_BITS  RAM write address.
- wrData  out  16  RAM write data; key or time in [15:0], key zero-extended.
- wrEnable  out  1  RAM write strobe, one cycle per word.
- busy  out  1  high in ARM, REC, CLOSE_K, CLOSE_T, HDR0, HDR1.
- done  out  1  high in DONE.
- full  out  1  high once noteCount has reached MAX_NOTES in the current take.
- noteCount  out  ADDRESS_BITS  pairs written so far.

Behaviour:
- MAX_NOTES = 2^(ADDRESS_BITS-1) - 1, which is 63 at the default width.
- Reset (reset == 0 at a clock edge):
  - state IDLE; all outputs 0.
  - msCount, tickCount and noteCount cleared; no header written.
  - Applies from any state, including mid-take.
- IDLE:
  - record == 0 → ARM; noteCount cleared; full cleared.
- ARM:
  - waits for key != 0.
  - On that cycle: curKey <= key, tickCount/msCount cleared → REC.
  - stop in ARM → HDR0, giving an empty take with count 0.
- REC:
  - tickCount increments every cycle; at CLOCK_FREQUENCY/1000 - 1 it wraps to 0 and msCount increments.
  - Segment end is one of:
    - (a) key != curKey;
    - (b) msCount reaches MAX_MS;
    - (c) stop.
  - On segment end:
    - If msCount ≥ 1, latch pendKey = curKey and pendTime = msCount, then → CLOSE_K.
    - If msCount == 0, discard the segment (glitch filter). Go to REC for (a), or HDR0 for (c).
    - In both cases curKey <= key, or keeps the same key for (b), and the counters clear the same cycle. Timing of the new segment runs through CLOCK_FREQUENCY/1000 < 2 is illegal.
  - Priority: stop > MAX_MS > key change. If stop and a key change occur together, the current segment is closed and no new segment starts.
- CLOSE_K:
  - wrAddress = 2·noteCount + 2, wrData = pendKey, wrEnable = 1 → CLOSE_T.
- CLOSE_T:
  - wrAddress = 2·noteCount + 3, wrData = pendTime, wrEnable = 1; noteCount increments.
  - Next state is HDR0 if the segment ended on stop or the new noteCount == MAX_NOTES (full <= 1). Otherwise REC.
  - REC timing continues during CLOSE_K/CLOSE_T: the ms counters run in all busy recording states.
  - A key change arriving in CLOSE_K/CLOSE_T updates curKey and discards the prior sub-ms segment, since msCount is 0 by construction.
- HDR0:
  - wrAddress 0, wrData = noteCount zero-extended, wrEnable = 1 → HDR1.
- HDR1:
  - wrAddress 1, wrData 0, wrEnable = 1 → DONE.
- DONE:
  - done = 1; record == 0 → ARM, starting a new take that overwrites the RAM.
- Widths and limits:
  - msCount is 16-bit and never exceeds MAX_MS; a held key longer than MAX_MS produces consecutive pairs with the same key.
  - Rest segments (key 0) are recorded as pairs exactly like notes.
  - The leading rest before the first key is not recorded (ARM).
- enable low: holds everything, including pending writes; resumes where it left off.

Test Plan (CLOCK_FREQUENCY=10000, i.e. 10 cycles/ms, ADDRESS_BITS=7):
- Reset then record=0, key=40 for 35 cycles, key=0 for 20 cycles, stop → writes [2]=40, [3]=3, [4]=0, [5]=2, [0]=2, [1]=0; done=1; noteCount=2.
- Key 40 → 41 → 40, with 41 held for 4 cycles (<1 ms) → no pair for 41; only 40 pairs appear in the RAM, and wrEnable never carries key 41.
- MAX_MS=3, key=50 held 75 cycles, stop → pairs (50,3), (50,3) then (50,1); header count 3.
- Alternate keys 1/2 every 12 cycles, 70 changes → full=1 after pair 63, last data write at address 127, header 63, done=1, further key changes ignored.
- stop and a key change in the same REC cycle → current segment closed once, then header; no extra pair.
- reset=0 asserted in CLOSE_T mid-take → next cycle state IDLE, wrEnable=0, busy=0, noteCount=0, no header write; enable=0 for 50 cycles during REC → msCount unchanged; the resulting time value excludes the frozen cycles.

Source files
------------

// File: rtl/melody_recorder.sv
// rtl/melody_recorder.sv - records a live key stream as (key, ms) pairs into the melody RAM
// Word 0 holds the note count, word 1 is zero, pair n lives at words 2n+2 (key) and 2n+3 (time).

module melody_recorder #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int ADDRESS_BITS    = 7,
    parameter int MAX_MS          = 65535
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    record,
    input  logic                    stop,
    input  logic [6:0]              key,
    output logic [ADDRESS_BITS-1:0] wrAddress,
    output logic [15:0]             wrData,
    output logic                    wrEnable,
    output logic                    busy,
    output logic                    done,
    output logic                    full,
    output logic [ADDRESS_BITS-1:0] noteCount
);

    localparam int TICKS     = CLOCK_FREQUENCY / 1000;
    localparam int TICK_BITS = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [TICK_BITS-1:0]    TICK_LAST = TICK_BITS'(TICKS - 1);
    localparam logic [15:0]             MAX_MS_W  = 16'(MAX_MS);
    localparam logic [ADDRESS_BITS-1:0] MAX_NOTES = ADDRESS_BITS'((1 << (ADDRESS_BITS - 1)) - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        REC,
        CLOSE_K,
        CLOSE_T,
        HDR0,
        HDR1,
        DONE
    } recorderState;

    recorderState state, stateNext;

    logic [6:0]              curKey, curKeyNext;
    logic [TICK_BITS-1:0]    tickCount, tickNext;
    logic [15:0]             msCount, msNext;
    logic [ADDRESS_BITS-1:0] noteNext;
    logic                    fullNext;
    logic [6:0]              pendKey, pendKeyNext;
    logic [15:0]             pendTime, pendTimeNext;
    logic                    stopSeen, stopSeenNext;

    logic                    writeReq;
    logic                    counterRun;
    logic                    counterClear;

    logic                    atMax;
    logic                    keyChange;
    logic                    lastNote;
    logic [ADDRESS_BITS-1:0] keyAddr;
    logic [ADDRESS_BITS-1:0] timeAddr;
    logic [15:0]             headerData;

    assign atMax      = (msCount == MAX_MS_W);
    assign keyChange  = (key != curKey);
    assign lastNote   = ((noteCount + ADDRESS_BITS'(1)) == MAX_NOTES);
    assign keyAddr    = {noteCount[ADDRESS_BITS-2:0], 1'b0} + ADDRESS_BITS'(2);
    assign timeAddr   = keyAddr + ADDRESS_BITS'(1);
    assign headerData = {{(16 - ADDRESS_BITS){1'b0}}, noteCount};

    // A frozen block must not strobe the RAM; the pending write replays on resume.
    assign wrEnable = writeReq && enable;
    assign busy     = (state == ARM) || (state == REC) || (state == CLOSE_K) ||
                      (state == CLOSE_T) || (state == HDR0) || (state == HDR1);
    assign done     = (state == DONE);

    always_comb begin
        stateNext    = state;
        curKeyNext   = curKey;
        tickNext     = tickCount;
        msNext       = msCount;
        noteNext     = noteCount;
        fullNext     = full;
        pendKeyNext  = pendKey;
        pendTimeNext = pendTime;
        stopSeenNext = stopSeen;
        writeReq     = 1'b0;
        wrAddress    = '0;
        wrData       = '0;
        counterRun   = 1'b0;
        counterClear = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (!record) begin
                    stateNext = ARM;
                    noteNext  = '0;
                    fullNext  = 1'b0;
                end
            end
            ARM: begin
                if (stop) begin
                    stateNext = HDR0;
                end else if (key != 7'd0) begin
                    curKeyNext   = key;
                    counterClear = 1'b1;
                    stateNext    = REC;
                end
            end
            REC: begin
                counterRun = 1'b1;
                if (stop || atMax || keyChange) begin
                    counterClear = 1'b1;
                    // A MAX_MS split continues the same note in the next segment.
                    if (stop || !atMax) begin
                        curKeyNext = key;
                    end
                    if (msCount != 16'd0) begin
                        pendKeyNext  = curKey;
                        pendTimeNext = msCount;
                        stopSeenNext = stop;
                        stateNext    = CLOSE_K;
                    end else if (stop) begin
                        stateNext = HDR0;
                    end
                end
            end
            CLOSE_K, CLOSE_T: begin
                counterRun = 1'b1;
                writeReq   = 1'b1;
                if (stop) begin
                    stopSeenNext = 1'b1;
                end
                // The segment that started at the close is still sub-ms here.
                if (keyChange) begin
                    curKeyNext   = key;
                    counterClear = 1'b1;
                end
                if (state == CLOSE_K) begin
                    wrAddress = keyAddr;
                    wrData    = {9'd0, pendKey};
                    stateNext = CLOSE_T;
                end else begin
                    wrAddress = timeAddr;
                    wrData    = pendTime;
                    noteNext  = noteCount + ADDRESS_BITS'(1);
                    if (lastNote) begin
                        fullNext = 1'b1;
                    end
                    stateNext = (stopSeen || stop || lastNote) ? HDR0 : REC;
                end
            end
            HDR0: begin
                writeReq  = 1'b1;
                wrAddress = '0;
                wrData    = headerData;
                stateNext = HDR1;
            end
            HDR1: begin
                writeReq  = 1'b1;
                wrAddress = ADDRESS_BITS'(1);
                wrData    = '0;
                stateNext = DONE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (counterClear) begin
            tickNext = '0;
            msNext   = '0;
        end else if (counterRun) begin
            if (tickCount == TICK_LAST) begin
                tickNext = '0;
                if (!atMax) begin
                    msNext = msCount + 16'd1;
                end
            end else begin
                tickNext = tickCount + TICK_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            curKey    <= '0;
            tickCount <= '0;
            msCount   <= '0;
            noteCount <= '0;
            full      <= 1'b0;
            pendKey   <= '0;
            pendTime  <= '0;
            stopSeen  <= 1'b0;
        end else if (enable) begin
            state     <= stateNext;
            curKey    <= curKeyNext;
            tickCount <= tickNext;
            msCount   <= msNext;
            noteCount <= noteNext;
            full      <= fullNext;
            pendKey   <= pendKeyNext;
            pendTime  <= pendTimeNext;
            stopSeen  <= stopSeenNext;
        end
    end

endmodule
